int_ctrl: RTL and testbench

Interrupt controller for the pipelined core; it sits beside the decode stage and is the other end of its interrupt interface. On an external request it flushes the pipe, snapshots the link register, flags and resume PC, then redirects fetch to the handler. When a return-from-interrupt instruction (opcode 5'b11111) reaches decode, it drives the restore strobe with the saved LR/FL and redirects fetch back to the saved PC.

---
 rtl/int_ctrl.sv | 73 +++++++
 tb/tb_int_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt entry/return sequencer (flush, snapshot, redirect, restore).
// Optional `INT_PENDING_LATCH_EN: remember requests seen outside IDLE and replay them.
module int_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0600_F000,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_req,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] LR,
  input  logic [1:0]  FL,
  input  logic [31:0] resume_PC,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_PC,
  output logic        restore,
  output logic [31:0] LR_before_int,
  output logic [1:0]  FL_before_int,
  output logic        int_active,
  output logic        int_ack
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, FLUSH, DISPATCH, ACTIVE, RESTORE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] saved_pc;
  logic go, rin, unused_bits;
  assign unused_bits = ^instr[26:0];
  assign rin = instr_valid && instr[31:27] == 5'b11111;
`ifdef INT_PENDING_LATCH_EN
  logic pending;
  always_ff @(posedge clk)
    if (!rst_n) pending <= 1'b0;
    else if (state != IDLE && int_req) pending <= 1'b1;
    else if (state == IDLE) pending <= 1'b0;
  assign go = int_req || pending;
`else
  assign go = int_req;
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE     ? (go ? FLUSH : IDLE) :
                state == FLUSH    ? (cnt <= CW'(1) ? DISPATCH : FLUSH) :
                state == DISPATCH ? ACTIVE :
                state == ACTIVE   ? (rin ? RESTORE : ACTIVE) : IDLE;
  // Counter and snapshot load together on acceptance; snapshots hold until the next one.
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt           <= '0;
      saved_pc      <= '0;
      LR_before_int <= '0;
      FL_before_int <= '0;
    end else if (state == IDLE && go) begin
      cnt           <= CW'(FLUSH_CYCLES);
      saved_pc      <= resume_PC;
      LR_before_int <= LR;
      FL_before_int <= FL;
    end else if (state == FLUSH && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  always_comb begin
    flush       = state == FLUSH || state == DISPATCH || state == RESTORE;
    pc_redirect = state == DISPATCH || state == RESTORE;
    redirect_PC = state == DISPATCH ? HANDLER_ADDR : state == RESTORE ? saved_pc : 32'h0;
    restore     = state == RESTORE;
    int_active  = state == ACTIVE || state == RESTORE;
    int_ack     = state == FLUSH && cnt == CW'(FLUSH_CYCLES);
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed and random checks of int_ctrl against a cycle-timeline model.
module tb_int_ctrl;
  localparam int          F = 3;
  localparam logic [31:0] H = 32'h0600_F000;
  logic        clk = 1'b0;
  logic        rst_n, int_req, instr_valid;
  logic [31:0] instr, LR, resume_PC;
  logic [1:0]  FL;
  logic        flush, pc_redirect, restore, int_active, int_ack;
  logic [31:0] redirect_PC, LR_before_int;
  logic [1:0]  FL_before_int;
  int checks = 0, errors = 0;
  // Model: cycles since acceptance (-1 when not entering), handler running, return cycle.
  int          m_since = -1;
  bit          m_hand, m_ret, m_pend;
  logic [31:0] m_lr, m_pc;
  logic [1:0]  m_fl;

  int_ctrl #(.HANDLER_ADDR(H), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .instr(instr), .instr_valid(instr_valid),
    .LR(LR), .FL(FL), .resume_PC(resume_PC), .flush(flush), .pc_redirect(pc_redirect),
    .redirect_PC(redirect_PC), .restore(restore), .LR_before_int(LR_before_int),
    .FL_before_int(FL_before_int), .int_active(int_active), .int_ack(int_ack));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit disp;
    disp = m_since == F + 1;
    chk("flush", 32'(flush), 32'((m_since >= 1 && m_since <= F + 1) || m_ret));
    chk("int_ack", 32'(int_ack), 32'(m_since == 1));
    chk("pc_redirect", 32'(pc_redirect), 32'(disp || m_ret));
    chk("redirect_PC", redirect_PC, disp ? H : m_ret ? m_pc : 32'h0);
    chk("restore", 32'(restore), 32'(m_ret));
    chk("int_active", 32'(int_active), 32'(m_hand || m_ret));
    chk("LR_before_int", LR_before_int, m_lr);
    chk("FL_before_int", 32'(FL_before_int), 32'(m_fl));
  endtask

  task automatic step(input bit r, input bit req, input logic [31:0] ins, input bit v,
                      input logic [31:0] lr, input logic [1:0] fl, input logic [31:0] pc);
    bit idle;
    rst_n = r; int_req = req; instr = ins; instr_valid = v; LR = lr; FL = fl; resume_PC = pc;
    idle = m_since < 0 && !m_hand && !m_ret;
    if (!r) begin
      m_since = -1; m_hand = 0; m_ret = 0; m_pend = 0; m_lr = 0; m_fl = 0; m_pc = 0;
    end else begin
`ifdef INT_PENDING_LATCH_EN
      if (!idle && req) m_pend = 1;
`endif
      if (m_ret) begin
        m_ret = 0; m_hand = 0;
      end else if (m_hand) begin
        if (v && ins[31:27] == 5'h1f) m_ret = 1;
      end else if (m_since > 0) begin
        if (m_since == F + 1) begin m_since = -1; m_hand = 1; end
        else m_since++;
      end else if (req || m_pend) begin
        m_since = 1; m_lr = lr; m_fl = fl; m_pc = pc; m_pend = 0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step(input logic [31:0] ins, input bit v);
    step(1, 0, ins, v, 32'h0, 2'b00, 32'h0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'hF800_0000, 1, 32'h1234, 2'b11, 32'h5678);
    chk("reset_flush", 32'(flush), 32'h0);
    idle_step(32'h0, 0);
    // Stray return instruction in IDLE is ignored.
    idle_step(32'hF800_0000, 1);
    chk("stray_restore", 32'(restore), 32'h0);
    chk("stray_redirect", 32'(pc_redirect), 32'h0);
    // Entry.
    step(1, 1, 32'h0, 0, 32'h0600_0040, 2'b10, 32'h0600_0100);
    chk("entry_ack", 32'(int_ack), 32'h1);
    idle_step(32'h0, 0);
    chk("entry_flush2", 32'(flush), 32'h1);
    idle_step(32'h0, 0);
    chk("entry_flush3", 32'(flush), 32'h1);
    idle_step(32'h0, 0);
    chk("dispatch_pc", redirect_PC, 32'h0600_F000);
    idle_step(32'h0, 0);
    chk("active", 32'(int_active), 32'h1);
    chk("saved_lr", LR_before_int, 32'h0600_0040);
    chk("saved_fl", 32'(FL_before_int), 32'h2);
    idle_step(32'hF800_0000, 0);
    chk("rin_invalid", 32'(restore), 32'h0);
    idle_step(32'hFFFF_FFFF, 1);
    chk("ret_restore", 32'(restore), 32'h1);
    chk("ret_pc", redirect_PC, 32'h0600_0100);
    idle_step(32'h0, 0);
    chk("ret_idle", 32'(int_active), 32'h0);
    // Simultaneous request and return instruction in IDLE.
    step(1, 1, 32'hF800_0000, 1, 32'hA, 2'b01, 32'hB);
    chk("simul_restore", 32'(restore), 32'h0);
    chk("simul_ack", 32'(int_ack), 32'h1);
    idle_step(32'h0, 0);
    idle_step(32'h0, 0);
    // Reset on the last FLUSH cycle aborts entry.
    step(0, 0, 32'h0, 0, 32'h0, 2'b00, 32'h0);
    chk("abort_flush", 32'(flush), 32'h0);
    chk("abort_lr", LR_before_int, 32'h0);
    for (int i = 0; i < 6; i++) idle_step(32'hF800_0000, 1);
    // Request during handler.
    step(1, 1, 32'h0, 0, 32'h11, 2'b01, 32'h22);
    for (int i = 0; i < F + 1; i++) idle_step(32'h0, 0);
    step(1, 1, 32'h0, 0, 32'h33, 2'b10, 32'h44);
    idle_step(32'hF800_0000, 1);
    step(1, 0, 32'h0, 0, 32'h55, 2'b11, 32'h0600_0200);
    chk("nest_idle", 32'(int_active), 32'h0);
    idle_step(32'h0, 0);
`ifdef INT_PENDING_LATCH_EN
    chk("nest_flush", 32'(flush), 32'h1);
`else
    chk("nest_flush", 32'(flush), 32'h0);
`endif
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:27] = 5'h1f;
      step($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0, ins, 1'($urandom),
           $urandom, 2'($urandom), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
